// File: rtl/fir_pkg.sv
// Shared constants for the FIR decimation output path.
package fir_pkg;
    localparam int SAMPLE_W  = 16;
    localparam int DECIM_DEF = 4;
    localparam int DEPTH_DEF = 8;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead circular buffer with registered head sample, valid flag and occupancy count.
module sync_fifo
    import fir_pkg::*;
#(
    parameter int DW    = SAMPLE_W,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DW-1:0]            din_i,
    output logic [DW-1:0]            dout_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, rd_nxt_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] head_q, head_d;
    logic          valid_q, valid_d;
    logic          full_s, empty_s, push_s, pop_s;

    assign full_s  = (cnt_q == CW'(DEPTH));
    assign empty_s = (cnt_q == CW'(0));
    assign pop_s   = pop_i && !empty_s;
    assign push_s  = push_i && (!full_s || pop_s);

    // Next-state for pointers, count and the registered head-of-buffer sample.
    always_comb begin
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        rd_nxt_s = rd_q + AW'(1);
        if (push_s) begin
            wr_d = wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_nxt_s;
        end else begin
            rd_d = rd_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // Incoming sample becomes head only when it lands in an empty (or emptying) buffer.
        if (push_s && (empty_s || (pop_s && cnt_q == CW'(1)))) begin
            head_d = din_i;
        end else if (pop_s) begin
            head_d = mem_q[rd_nxt_s];
        end else begin
            head_d = head_q;
        end
        valid_d = (cnt_d != CW'(0));
    end

    // Pointer, count and head registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= AW'(0);
            rd_q    <= AW'(0);
            cnt_q   <= CW'(0);
            head_q  <= DW'(0);
            valid_q <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end

    // Sample storage; contents are qualified by the count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_q] <= din_i;
        end
    end

    assign dout_o  = head_q;
    assign valid_o = valid_q;
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign count_o = cnt_q;
endmodule

// File: rtl/fir_decim_buffer.sv
// Decimates the FIR output stream by DECIM and queues the kept samples for a ready/valid consumer.
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int DW    = SAMPLE_W,
    parameter int DECIM = DECIM_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          din,
    input  logic                   din_en,
    output logic [DW-1:0]          dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clr_ovf
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PW-1:0] ph_q, ph_d;
    logic          ovf_q, ovf_d;
    logic          sel_s, pop_s, drop_s, full_s, empty_s;

    assign sel_s  = din_en && (ph_q == PW'(0));
    assign pop_s  = dout_valid && dout_ready;
    assign drop_s = sel_s && full_s && !pop_s;

    // Phase only moves on real FIR samples, so gaps in din_en do not shift the selection.
    always_comb begin
        ph_d = ph_q;
        if (din_en) begin
            if (ph_q == PW'(DECIM - 1)) begin
                ph_d = PW'(0);
            end else begin
                ph_d = ph_q + PW'(1);
            end
        end else begin
            ph_d = ph_q;
        end
    end

    // Sticky overflow: a drop on the same edge as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Phase and overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph_q  <= PW'(0);
            ovf_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            ovf_q <= ovf_d;
        end
    end

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (sel_s),
        .pop_i   (pop_s),
        .din_i   (din),
        .dout_o  (dout),
        .valid_o (dout_valid),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count)
    );

    assign overflow = ovf_q;

    logic unused_s;
    assign unused_s = empty_s;
endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench: three buffer instances (DECIM 4, 1, 2) exercised with hand-computed expectations.
module tb_fir_decim_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic        rst_a, en_a, rdy_a, clr_a, val_a, ovf_a;
    logic [15:0] din_a, dout_a;
    logic [3:0]  cnt_a;
    logic        rst_b, en_b, rdy_b, clr_b, val_b, ovf_b;
    logic [15:0] din_b, dout_b;
    logic [3:0]  cnt_b;
    logic        rst_c, en_c, rdy_c, clr_c, val_c, ovf_c;
    logic [15:0] din_c, dout_c;
    logic [3:0]  cnt_c;

    fir_decim_buffer #(.DW(16), .DECIM(4), .DEPTH(8)) u_dut_a (
        .clk(clk), .rst(rst_a), .din(din_a), .din_en(en_a), .dout(dout_a),
        .dout_valid(val_a), .dout_ready(rdy_a), .count(cnt_a),
        .overflow(ovf_a), .clr_ovf(clr_a));

    fir_decim_buffer #(.DW(16), .DECIM(1), .DEPTH(8)) u_dut_b (
        .clk(clk), .rst(rst_b), .din(din_b), .din_en(en_b), .dout(dout_b),
        .dout_valid(val_b), .dout_ready(rdy_b), .count(cnt_b),
        .overflow(ovf_b), .clr_ovf(clr_b));

    fir_decim_buffer #(.DW(16), .DECIM(2), .DEPTH(8)) u_dut_c (
        .clk(clk), .rst(rst_c), .din(din_c), .din_en(en_c), .dout(dout_c),
        .dout_valid(val_c), .dout_ready(rdy_c), .count(cnt_c),
        .overflow(ovf_c), .clr_ovf(clr_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b0; rdy_a = 1'b0; clr_a = 1'b0; din_a = 16'd0;
        rst_b = 1'b0; en_b = 1'b0; rdy_b = 1'b0; clr_b = 1'b0; din_b = 16'd0;
        rst_c = 1'b0; en_c = 1'b0; rdy_c = 1'b0; clr_c = 1'b0; din_c = 16'd0;
        #2;
        chk("rst_dout",  dout_a, 0);
        chk("rst_valid", val_a,  0);
        chk("rst_count", cnt_a,  0);
        chk("rst_ovf",   ovf_a,  0);
        chk("rst_valid_b", val_b, 0);
        chk("rst_count_c", cnt_c, 0);
        #10;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        // Scenario 1: DECIM=4 continuous stream, pulses carry 1, 5, 9
        en_a = 1'b1; rdy_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            din_a = 16'(k);
            tick();
            chk("s1_valid", val_a, ((k % 4) == 1) ? 1 : 0);
            if ((k % 4) == 1) chk("s1_dout", dout_a, k);
        end
        en_a = 1'b0;

        // Scenario 2: DECIM=1, fill past full with consumer stalled
        rdy_b = 1'b0; en_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            din_b = 16'(10 + k);
            tick();
            chk("s2_count", cnt_b, (k + 1 > 8) ? 8 : k + 1);
            if (k == 7) chk("s2_ovf_before", ovf_b, 0);
            if (k == 8) chk("s2_ovf_set", ovf_b, 1);
        end
        en_b = 1'b0;
        chk("s2_head", dout_b, 10);
        rdy_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("s2_pop_valid", val_b, 1);
            chk("s2_pop_dout", dout_b, 10 + i);
            tick();
        end
        rdy_b = 1'b0;
        chk("s2_empty_count", cnt_b, 0);
        chk("s2_empty_valid", val_b, 0);
        chk("s2_ovf_sticky", ovf_b, 1);

        // Scenario 6a: clear overflow
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        chk("s6_clear", ovf_b, 0);

        en_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din_b = 16'(20 + i);
            tick();
        end
        chk("s3_full_count", cnt_b, 8);
        chk("s3_full_ovf", ovf_b, 0);

        // Scenario 3: full buffer with push and pop on every edge
        rdy_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din_b = 16'(30 + i);
            chk("s3_order", dout_b, 20 + i);
            tick();
            chk("s3_count", cnt_b, 8);
            chk("s3_ovf", ovf_b, 0);
        end

        // Scenario 6b: clear coincident with a drop
        rdy_b = 1'b0; din_b = 16'd99; clr_b = 1'b1;
        tick();
        clr_b = 1'b0; en_b = 1'b0;
        chk("s6_drop_wins", ovf_b, 1);
        chk("s6_drop_count", cnt_b, 8);
        chk("s6_drop_head", dout_b, 30);
        rdy_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("s6_pop_dout", dout_b, 30 + i);
            tick();
        end
        rdy_b = 1'b0;
        chk("s5_pre_count", cnt_b, 5);
        chk("s5_pre_ovf", ovf_b, 1);

        // Scenario 4: DECIM=2 with gaps between samples
        rdy_c = 1'b0;
        for (int j = 0; j < 6; j++) begin
            en_c = 1'b1; din_c = 16'(j);
            tick();
            chk("s4_count", cnt_c, (j / 2) + 1);
            en_c = 1'b0; din_c = 16'(100 + j);
            tick();
        end
        rdy_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("s4_dout", dout_c, 2 * i);
            tick();
        end
        rdy_c = 1'b0;
        chk("s4_drained", cnt_c, 0);
        en_c = 1'b1; din_c = 16'd7;
        tick();
        en_c = 1'b0;
        chk("s4_odd_phase_count", cnt_c, 1);

        // Scenario 5: asynchronous reset mid-cycle
        #3;
        rst_b = 1'b0; rst_c = 1'b0;
        #1;
        chk("s5_count", cnt_b, 0);
        chk("s5_valid", val_b, 0);
        chk("s5_ovf", ovf_b, 0);
        chk("s5_dout", dout_b, 0);
        chk("s5_count_c", cnt_c, 0);
        chk("s5_valid_c", val_c, 0);
        #2;
        rst_b = 1'b1; rst_c = 1'b1;
        en_b = 1'b1; din_b = 16'd55;
        en_c = 1'b1; din_c = 16'd42;
        tick();
        en_b = 1'b0; en_c = 1'b0;
        chk("s5_after_valid", val_b, 1);
        chk("s5_after_dout", dout_b, 55);
        chk("s5_after_count", cnt_b, 1);
        chk("s5_after_valid_c", val_c, 1);
        chk("s5_after_dout_c", dout_c, 42);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
